uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_core.sv | 122 ++++++++++++
 rtl/uart_tx_arbiter.sv | 80 ++++++++
 tb/tb_uart_tx_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the arbitrated UART transmitter: frame states,
// default width / baud constants and a counter-width helper.
// Optional feature macro: UART_TX_ARB_PARITY_EN (adds an even-parity bit).
package uart_pkg;

    localparam int C_UART_WIDTH        = 8;
    localparam int C_CLK_2_BAUD_RATIO  = 520;   // 5 MHz / 9600 baud
    localparam int C_N_REQ             = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_ARB_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART frame serializer: START, DATA (LSB first), optional PARITY, STOP.
// Each bit lasts P_CLK_2_BAUD_RATIO cycles. A frame begins on the edge where
// start is seen while ready is high; the start bit appears the next cycle.
// Optional feature macro: UART_TX_ARB_PARITY_EN (even parity after data).
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int P_UART_WIDTH       = C_UART_WIDTH,
    parameter int P_CLK_2_BAUD_RATIO = C_CLK_2_BAUD_RATIO
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic [P_UART_WIDTH-1:0] data,
    output logic                    ready,
    output logic                    serial_out,
    output logic                    busy
);

    localparam int BAUD_W = cnt_width(P_CLK_2_BAUD_RATIO - 1);
    localparam int BIT_W  = cnt_width(P_UART_WIDTH - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(P_CLK_2_BAUD_RATIO - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(P_UART_WIDTH - 1);

    uart_state_t             state_reg;
    logic [BAUD_W-1:0]       baud_cnt_reg;
    logic [BIT_W-1:0]        bit_cnt_reg;
    logic [P_UART_WIDTH-1:0] shift_reg;
    logic                    parity_reg;
    logic                    serial_out_reg;
    logic                    busy_reg;
    logic                    baud_done;

    assign baud_done  = (baud_cnt_reg == BAUD_LAST);
    assign ready      = (state_reg == ST_IDLE);
    assign serial_out = serial_out_reg;
    assign busy       = busy_reg;

    // Frame sequencer; line level and busy are registered so they change with the state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            serial_out_reg <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg      <= data;
                        parity_reg     <= ^data;
                        baud_cnt_reg   <= '0;
                        bit_cnt_reg    <= '0;
                        serial_out_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt_reg   <= '0;
                        serial_out_reg <= shift_reg[0];
                        state_reg      <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            bit_cnt_reg <= '0;
`ifdef UART_TX_ARB_PARITY_EN
                            serial_out_reg <= parity_reg;
                            state_reg      <= ST_PARITY;
`else
                            serial_out_reg <= 1'b1;
                            state_reg      <= ST_STOP;
`endif
                        end else begin
                            // Next bit is shift_reg[1] before the shift lands.
                            bit_cnt_reg    <= bit_cnt_reg + 1'b1;
                            serial_out_reg <= shift_reg[1];
                            shift_reg      <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt_reg   <= '0;
                        serial_out_reg <= 1'b1;
                        state_reg      <= ST_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        busy_reg     <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    serial_out_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from P_N_REQ requesters.
// While the serializer is idle, exactly one valid requester sees req_ready,
// searched from the priority pointer upward; the pointer then moves past it.
// Optional feature macro: UART_TX_ARB_PARITY_EN (handled inside uart_tx_core).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int P_UART_WIDTH       = C_UART_WIDTH,
    parameter int P_N_REQ            = C_N_REQ,
    parameter int P_CLK_2_BAUD_RATIO = C_CLK_2_BAUD_RATIO
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic [P_N_REQ-1:0]                req_valid,
    input  logic [P_N_REQ*P_UART_WIDTH-1:0]   req_data,
    output logic [P_N_REQ-1:0]                req_ready,
    output logic                              serial_out,
    output logic                              busy,
    output logic [$clog2(P_N_REQ)-1:0]        grant_idx
);

    localparam int IDX_W = $clog2(P_N_REQ);

    logic [P_UART_WIDTH-1:0] req_bytes [P_N_REQ];
    logic [IDX_W-1:0]        ptr_reg;
    logic [IDX_W-1:0]        grant_reg;
    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        cand_idx;
    logic                    sel_valid;
    logic                    core_ready;
    logic                    start;

    for (genvar gi = 0; gi < P_N_REQ; gi++) begin : g_req
        assign req_bytes[gi] = req_data[gi*P_UART_WIDTH +: P_UART_WIDTH];
        // Ready is suppressed during reset even though the core reports idle.
        assign req_ready[gi] = core_ready && reset && sel_valid && (sel_idx == IDX_W'(gi));
    end

    // Pick the first valid requester at or after the priority pointer, wrapping.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < P_N_REQ; k++) begin
            cand_idx = IDX_W'((int'(ptr_reg) + k) % P_N_REQ);
            if (!sel_valid && req_valid[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign start     = core_ready && sel_valid;
    assign grant_idx = grant_reg;

    // Record the accepted requester and rotate priority just past it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ptr_reg   <= '0;
            grant_reg <= '0;
        end else if (start) begin
            grant_reg <= sel_idx;
            ptr_reg   <= (sel_idx == IDX_W'(P_N_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    uart_tx_core #(
        .P_UART_WIDTH      (P_UART_WIDTH),
        .P_CLK_2_BAUD_RATIO(P_CLK_2_BAUD_RATIO)
    ) u_core (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .data      (req_bytes[sel_idx]),
        .ready     (core_ready),
        .serial_out(serial_out),
        .busy      (busy)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with 4 requesters and 4 clocks per bit.
// A table of single-shot arbitration vectors is followed by hand-written
// sequences for back-to-back service, fairness, withdrawn requests and reset.
// Optional feature macro: UART_TX_ARB_PARITY_EN (frame grows to 11 bits).
module tb_uart_tx_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int R = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic           CLK;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           serial_out;
    logic           busy;
    logic [1:0]     grant_idx;

    int tests_run;
    int tests_failed;

    uart_tx_arbiter #(
        .P_UART_WIDTH      (W),
        .P_N_REQ           (N),
        .P_CLK_2_BAUD_RATIO(R)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .serial_out(serial_out),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        int             exp_idx;
        logic [W-1:0]   exp_byte;
    } vec_t;

    vec_t vecs [8];

    // Line levels in transmit order: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_ARB_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with requests already driven. Waits for acceptance,
    // checks the grant and every cycle of the frame, returns at the first idle
    // negedge after the frame. mode: 0 keep valids, 1 drop winner, 2 drop all.
    task automatic frame_check(input int exp_i, input logic [7:0] exp_b, input int mode);
        int           n;
        int           errs;
        logic [10:0]  fb;
        fb = frame_bits(exp_b);
        #1;
        n = 0;
        while (req_ready == '0 && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("accept_wait", n, 0);
        chk("ready_onehot", 32'(req_ready), 32'(4'b0001 << exp_i));
        chk("idle_busy", 32'(busy), 0);
        @(negedge CLK);
        if (mode == 1) req_valid[exp_i] = 1'b0;
        else if (mode == 2) req_valid = '0;
        chk("grant_idx", 32'(grant_idx), exp_i);
        errs = 0;
        for (int t = 0; t < FL*R; t++) begin
            if (t > 0) @(negedge CLK);
            if (serial_out !== fb[t/R] || busy !== 1'b1 || req_ready !== '0) errs++;
        end
        chk("frame_cycles", errs, 0);
        @(negedge CLK);
        chk("end_busy", 32'(busy), 0);
        chk("end_line", 32'(serial_out), 1);
        $display("[TB] frame req=%0d data=%02h grant=%0d wait=%0d bad_cycles=%0d",
                 exp_i, exp_b, grant_idx, n, errs);
    endtask

    initial begin
        int busy_cycles;
        int ready0_seen;

        tests_run    = 0;
        tests_failed = 0;

        // Pointer walk starting from 0 after reset.
        vecs[0] = '{4'b0010, 32'h0000A500, 1, 8'hA5};  // ptr 0 -> 2
        vecs[1] = '{4'b0001, 32'h0000003C, 0, 8'h3C};  // ptr 2 -> 1 (wraps)
        vecs[2] = '{4'b1001, 32'h5A0000C3, 3, 8'h5A};  // ptr 1 -> 0
        vecs[3] = '{4'b1100, 32'h81FF0000, 2, 8'hFF};  // ptr 0 -> 3
        vecs[4] = '{4'b0011, 32'h00009907, 0, 8'h07};  // ptr 3 -> 1 (wraps)
        vecs[5] = '{4'b0101, 32'h00330044, 2, 8'h33};  // ptr 1 -> 3
        vecs[6] = '{4'b1111, 32'hC8B7A695, 3, 8'hC8};  // ptr 3 -> 0
        vecs[7] = '{4'b0001, 32'h00000000, 0, 8'h00};  // ptr 0 -> 1

        // Reset state, with all requests asserted to prove ready stays low.
        reset     = 1'b0;
        req_valid = '1;
        req_data  = 32'h11223344;
        @(negedge CLK);
        #1;
        chk("rst_line", 32'(serial_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant_idx), 0);
        @(negedge CLK);
        req_valid = '0;
        reset     = 1'b1;
        @(negedge CLK);

        // Table-driven arbitration vectors.
        for (int v = 0; v < 8; v++) begin
            req_valid = vecs[v].valid;
            req_data  = vecs[v].data;
            frame_check(vecs[v].exp_idx, vecs[v].exp_byte, 2);
        end

        // All four requesting right after reset: served 0,1,2,3 with one idle cycle between.
        reset = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        reset     = 1'b1;
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        frame_check(0, 8'h11, 1);
        frame_check(1, 8'h22, 1);
        frame_check(2, 8'h33, 1);
        frame_check(3, 8'h44, 1);

        // Two requesters held continuously must alternate.
        req_data  = 32'hBBAA0000;
        req_valid = 4'b1100;
        frame_check(2, 8'hAA, 0);
        frame_check(3, 8'hBB, 0);
        frame_check(2, 8'hAA, 0);
        frame_check(3, 8'hBB, 0);
        req_valid = '0;

        // Requester 0 appears and withdraws while requester 1's frame is on the line.
        req_data  = 32'h00005E00;
        req_valid = 4'b0010;
        #1;
        chk("wd_ready1", 32'(req_ready), 32'(4'b0010));
        @(negedge CLK);
        req_valid   = '0;
        busy_cycles = 0;
        ready0_seen = 0;
        for (int c = 0; c < FL*R + 8; c++) begin
            if (c == 3)  req_valid[0] = 1'b1;
            if (c == 12) req_valid[0] = 1'b0;
            #1;
            if (req_ready[0] === 1'b1) ready0_seen++;
            if (busy === 1'b1) busy_cycles++;
            @(negedge CLK);
        end
        chk("wd_ready0", ready0_seen, 0);
        chk("wd_busy_len", busy_cycles, FL*R);
        chk("wd_grant", 32'(grant_idx), 1);
        $display("[TB] withdraw test busy_cycles=%0d ready0_seen=%0d", busy_cycles, ready0_seen);

        // Reset mid-frame: frame for 2 aborted at its cycle 15, 1 and 3 still pending.
        req_data  = 32'h63626100;
        req_valid = 4'b1110;
        #1;
        chk("mr_ready2", 32'(req_ready), 32'(4'b0100));
        @(negedge CLK);
        req_valid[2] = 1'b0;
        repeat (15) @(negedge CLK);
        chk("mr_line_before", 32'(serial_out), 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_line", 32'(serial_out), 1);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ready", 32'(req_ready), 0);
        chk("mr_grant", 32'(grant_idx), 0);
        $display("[TB] mid-frame reset line=%0b busy=%0b", serial_out, busy);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        frame_check(1, 8'h61, 1);
        frame_check(3, 8'h63, 1);

        // Nothing left pending: the aborted byte must not come back.
        busy_cycles = 0;
        for (int c = 0; c < 2*R; c++) begin
            #1;
            if (busy === 1'b1) busy_cycles++;
            @(negedge CLK);
        end
        chk("no_resend", busy_cycles, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
